// File: rtl/axi_fifo_bfm_pkg.sv
// Shared definitions for the sync-FIFO BFM drain logic.
//   - DRAIN_WIDTH / DRAIN_LEN_W : default data width and packet-length width
//   - drain_state_e             : drain FSM state (IDLE, RUN)
//   - drain_dbg_t               : debug snapshot exported by axis_fifo_drain
//                                 (FSM state, skid occupancy, read in flight)
package axi_fifo_bfm_pkg;

  localparam int DRAIN_WIDTH = 128;
  localparam int DRAIN_LEN_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } drain_state_e;

  typedef struct packed {
    drain_state_e state;
    logic [1:0]   occ;
    logic         inflight;
  } drain_dbg_t;

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: output register plus a 2-entry skid store.
//   Words arrive with in_valid (no back-pressure; the producer guarantees room
//   by limiting occ + words in flight to 2). The output register presents the
//   oldest word; the skid entries absorb words that arrive while the output is
//   stalled.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      write strobe for in_data this cycle
//   in_data       word to store
//   out_valid     output register holds a word
//   out_ready     consumer accepts the output word this cycle
//   out_data      output word (held stable while out_valid && !out_ready)
//   occ           skid entries held (0..2), not counting the output register
// Handshake: a word moves out when out_valid && out_ready on a rising edge.
module axis_skid_buf #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] s0;  // oldest skid entry
  logic [WIDTH-1:0] s1;
  logic             advance;

  // The output register can take a new word when empty or being consumed.
  assign advance = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      s0        <= '0;
      s1        <= '0;
      occ       <= 2'd0;
    end else if (advance) begin
      if (occ == 2'd0) begin
        // Incoming word bypasses the skid store.
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end else begin
        out_valid <= 1'b1;
        out_data  <= s0;
        if (occ == 2'd2) begin
          s0 <= s1;
          if (in_valid) s1 <= in_data;
          else          occ <= 2'd1;
        end else begin
          if (in_valid) s0 <= in_data;
          else          occ <= 2'd0;
        end
      end
    end else if (in_valid) begin
      // Output stalled: park the word behind any already held.
      if (occ == 2'd0) s0 <= in_data;
      else             s1 <= in_data;
      occ <= occ + 2'd1;
    end
  end

endmodule

// File: rtl/axis_fifo_drain.sv
// axis_fifo_drain: pops words from a sync FIFO (1-cycle registered read
// latency) and presents them as an AXI4-Stream master, grouped into packets of
// cfg_pkt_len beats (0 treated as 1) with TLAST on the final beat.
// Optional build macro: AXIS_FIFO_DRAIN_STATS_EN adds stat_beats / stat_pkts.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   enable                     allow new packets; sampled at packet boundaries
//   cfg_pkt_len                beats per packet, latched at packet start
//   fifo_empty, fifo_rd_en     FIFO status and pop request
//   fifo_rd_data               FIFO data, valid the cycle after a pop
//   m_axis_tvalid/tready/tdata/tlast   AXI4-Stream master
//   busy                       FSM running, or words buffered or in flight
//   dbg                        FSM state, skid occupancy, read in flight
//   stat_beats, stat_pkts      (stats build) handshake / tlast-handshake counts
// Handshake: a beat transfers on a rising edge with tvalid && tready; tdata and
// tlast are held while tvalid && !tready.
module axis_fifo_drain
  import axi_fifo_bfm_pkg::*;
#(
  parameter int WIDTH = DRAIN_WIDTH,
  parameter int LEN_W = DRAIN_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [LEN_W-1:0] cfg_pkt_len,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             busy,
  output drain_dbg_t       dbg
`ifdef AXIS_FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_pkts
`endif
);

  drain_state_e     state, state_nx;
  logic [LEN_W-1:0] len_q, len_nx;
  logic [LEN_W-1:0] rd_cnt, rd_cnt_nx;
  logic [LEN_W-1:0] tx_cnt, tx_cnt_nx;
  logic [LEN_W-1:0] cfg_len;
  logic             inflight;
  logic [1:0]       occ;
  logic             hs;
  logic             last_beat;

  assign cfg_len   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign last_beat = (tx_cnt == len_q - LEN_W'(1));

  always_comb begin
    state_nx   = state;
    len_nx     = len_q;
    rd_cnt_nx  = rd_cnt;
    tx_cnt_nx  = tx_cnt;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx  = RUN;
          len_nx    = cfg_len;
          rd_cnt_nx = '0;
          tx_cnt_nx = '0;
        end
      end
      RUN: begin
        // Reserve a skid slot for every word already requested so a capture
        // can never find the buffer full; tready plays no part.
        fifo_rd_en = !fifo_empty && (rd_cnt < len_q) &&
                     (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
        rd_cnt_nx  = rd_cnt + LEN_W'(fifo_rd_en);
        tx_cnt_nx  = tx_cnt + LEN_W'(hs);
        if (hs && last_beat) begin
          // All words of this packet were popped before its last beat can
          // hand over, so no pop coincides with the relatch.
          len_nx    = cfg_len;
          rd_cnt_nx = '0;
          tx_cnt_nx = '0;
          if (!enable) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= LEN_W'(1);
      rd_cnt   <= '0;
      tx_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      len_q    <= len_nx;
      rd_cnt   <= rd_cnt_nx;
      tx_cnt   <= tx_cnt_nx;
      inflight <= fifo_rd_en;
    end
  end

  // A popped word appears on fifo_rd_data one cycle later; inflight marks it.
  axis_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inflight),
    .in_data  (fifo_rd_data),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data (m_axis_tdata),
    .occ      (occ)
  );

  assign m_axis_tlast = m_axis_tvalid && last_beat;
  assign busy         = (state != IDLE) || m_axis_tvalid || (occ != 2'd0) || inflight;
  assign dbg          = '{state: state, occ: occ, inflight: inflight};

`ifdef AXIS_FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else begin
      if (hs)                 stat_beats <= stat_beats + 32'd1;
      if (hs && m_axis_tlast) stat_pkts  <= stat_pkts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_fifo_drain.sv
// Bench for axis_fifo_drain: directed steps in one initial block, random data
// and random tready, a queue-based model of packet framing, and a sync-FIFO
// model with registered read data.
module tb_axis_fifo_drain;
  import axi_fifo_bfm_pkg::*;

  localparam int WIDTH = 128;
  localparam int LEN_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             enable;
  logic [LEN_W-1:0] cfg_pkt_len;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             busy;
  drain_dbg_t       dbg;
`ifdef AXIS_FIFO_DRAIN_STATS_EN
  logic [31:0]      stat_beats;
  logic [31:0]      stat_pkts;
`endif

  axis_fifo_drain #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_pkt_len  (cfg_pkt_len),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tdata (tdata),
    .m_axis_tlast (tlast),
    .busy         (busy),
    .dbg          (dbg)
`ifdef AXIS_FIFO_DRAIN_STATS_EN
    ,
    .stat_beats   (stat_beats),
    .stat_pkts    (stat_pkts)
`endif
  );

  // ---------------- sync FIFO model ----------------
  logic [WIDTH-1:0] mem [0:1023];
  logic [15:0]      wr_ptr = '0;
  logic [15:0]      rd_ptr = '0;
  logic             fifo_flush = 1'b0;
  logic             underflow_seen = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      if (fifo_empty) underflow_seen <= 1'b1;
      else begin
        fifo_rd_data <= mem[rd_ptr[9:0]];
        rd_ptr       <= rd_ptr + 16'd1;
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [WIDTH-1:0] exp_q[$];
  bit               last_q[$];
  int               hs_cyc[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int beats = 0;
  int pos = 0;          // beat position inside the packet being planned
  int pkts_left = 0;    // packets still to be emitted in the current test
  bit auto_en = 1'b0;
  int ready_mode = 0;   // 0 hold, 1 toggle, 2 random
  int stat_b = 0;
  int stat_p = 0;
  bit prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push n random words; when want is set, also plan them as beats of
  // packets of length len (0 behaves as 1).
  task automatic push_words(input int n, input int len, input bit want);
    int l;
    logic [WIDTH-1:0] w;
    l = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      mem[wr_ptr[9:0]] = w;
      wr_ptr = wr_ptr + 16'd1;
      if (want) begin
        exp_q.push_back(w);
        last_q.push_back(pos == l - 1);
        pos = (pos == l - 1) ? 0 : pos + 1;
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, then observe.
  task automatic step();
    logic [WIDTH-1:0] ed;
    bit el;
    @(negedge clk);
    cyc++;
    if (auto_en) enable = (pkts_left > 1);
    case (ready_mode)
      1: tready = ~tready;
      2: tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    #1;
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    chk("occ_over_2", WIDTH'(dbg.occ > 2'd2), WIDTH'(0));
    if (prev_stall) begin
      chk("hold_valid", WIDTH'(tvalid), WIDTH'(1));
      chk("hold_data", tdata, prev_data);
      chk("hold_last", WIDTH'(tlast), WIDTH'(prev_last));
    end
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL extra_beat: observed beat %0h expected none", tdata);
      end else begin
        ed = exp_q.pop_front();
        el = last_q.pop_front();
        chk("beat_data", tdata, ed);
        chk("beat_last", WIDTH'(tlast), WIDTH'(el));
        stat_b++;
        if (el) begin
          stat_p++;
          pkts_left--;
        end
      end
      beats++;
      hs_cyc.push_back(cyc);
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    chk("drain_left", WIDTH'(exp_q.size()), WIDTH'(0));
  endtask

  task automatic settle_idle(input string tag);
    for (int i = 0; i < 3; i++) step();
    chk({tag, "_busy"}, WIDTH'(busy), WIDTH'(0));
    chk({tag, "_state"}, WIDTH'(dbg.state), WIDTH'(IDLE));
  endtask

  task automatic new_test(input int len, input int pkts);
    cfg_pkt_len = LEN_W'(len);
    pkts_left = pkts;
    pos = 0;
    beats = 0;
    hs_cyc.delete();
  endtask

  task automatic flush_fifo();
    fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
  endtask

  initial begin
    int lat;
    int k;
    int rl;
    int rp;
    rst = 1'b1;
    enable = 1'b0;
    cfg_pkt_len = '0;
    tready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Reset state.
    chk("rst_tvalid", WIDTH'(tvalid), WIDTH'(0));
    chk("rst_tlast", WIDTH'(tlast), WIDTH'(0));
    chk("rst_tdata", tdata, WIDTH'(0));
    chk("rst_rd_en", WIDTH'(fifo_rd_en), WIDTH'(0));
    chk("rst_busy", WIDTH'(busy), WIDTH'(0));
    chk("rst_state", WIDTH'(dbg.state), WIDTH'(IDLE));
    rst = 1'b0;
    step();

    // 1: len=4, 8 words, tready=1 -> two packets, 3-cycle latency, 2-cycle gap.
    new_test(4, 2);
    auto_en = 1'b1;
    push_words(8, 4, 1'b1);
    step();
    enable = 1'b1;
    lat = 0;
    while (!tvalid && lat < 20) begin
      step();
      lat++;
    end
    chk("t1_latency", WIDTH'(lat), WIDTH'(3));
    drain(100);
    chk("t1_beats", WIDTH'(hs_cyc.size()), WIDTH'(8));
    if (hs_cyc.size() >= 8) begin
      chk("t1_burst_a", WIDTH'(hs_cyc[3] - hs_cyc[0]), WIDTH'(3));
      chk("t1_gap", WIDTH'(hs_cyc[4] - hs_cyc[3]), WIDTH'(3));
      chk("t1_burst_b", WIDTH'(hs_cyc[7] - hs_cyc[4]), WIDTH'(3));
    end
    settle_idle("t1");

    // 2: len=3, tready toggling, 6 words.
    new_test(3, 2);
    push_words(6, 3, 1'b1);
    ready_mode = 1;
    enable = 1'b1;
    drain(200);
    ready_mode = 0;
    tready = 1'b1;
    settle_idle("t2");

    // 3: len=5, FIFO starved after 2 words, refilled 10 cycles later.
    new_test(5, 1);
    push_words(2, 5, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t3_starved_valid", WIDTH'(tvalid), WIDTH'(0));
    chk("t3_starved_beats", WIDTH'(beats), WIDTH'(2));
    push_words(3, 5, 1'b1);
    drain(100);
    settle_idle("t3");

    // 4: enable dropped after beat 2 of a len=6 packet.
    new_test(6, 1);
    auto_en = 1'b0;
    push_words(6, 6, 1'b1);
    enable = 1'b1;
    k = 0;
    while (beats < 2 && k < 30) begin
      step();
      k++;
    end
    enable = 1'b0;
    drain(100);
    chk("t4_beats", WIDTH'(beats), WIDTH'(6));
    settle_idle("t4");
    push_words(2, 1, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk("t4_no_pop", WIDTH'(wr_ptr - rd_ptr), WIDTH'(2));
    chk("t4_no_valid", WIDTH'(tvalid), WIDTH'(0));
    flush_fifo();
    auto_en = 1'b1;

    // 5a: cfg_pkt_len=0 -> single-beat packets.
    new_test(0, 3);
    push_words(3, 0, 1'b1);
    enable = 1'b1;
    drain(100);
    settle_idle("t5a");

    // 5b: cfg change mid-packet affects only the next packet.
    new_test(4, 2);
    push_words(4, 4, 1'b1);
    push_words(2, 2, 1'b1);
    enable = 1'b1;
    k = 0;
    while (beats < 1 && k < 30) begin
      step();
      k++;
    end
    cfg_pkt_len = LEN_W'(2);
    drain(100);
    settle_idle("t5b");

    // Random: random length, packet count and tready.
    for (int r = 0; r < 3; r++) begin
      rl = $urandom_range(1, 4);
      rp = $urandom_range(2, 3);
      new_test(rl, rp);
      push_words(rl * rp, rl, 1'b1);
      ready_mode = 2;
      enable = 1'b1;
      drain(400);
      ready_mode = 0;
      tready = 1'b1;
      settle_idle("rand");
    end

    // 6: async reset mid-packet with 2 beats buffered.
    new_test(4, 1);
    tready = 1'b0;
    push_words(4, 4, 1'b1);
    enable = 1'b1;
    k = 0;
    while (!(tvalid && dbg.occ == 2'd1) && k < 20) begin
      step();
      k++;
    end
    chk("t6_buffered", WIDTH'(tvalid && dbg.occ == 2'd1), WIDTH'(1));
    #2 rst = 1'b1;
    #1;
    chk("t6_tvalid", WIDTH'(tvalid), WIDTH'(0));
    chk("t6_tlast", WIDTH'(tlast), WIDTH'(0));
    chk("t6_tdata", tdata, WIDTH'(0));
    chk("t6_rd_en", WIDTH'(fifo_rd_en), WIDTH'(0));
    chk("t6_busy", WIDTH'(busy), WIDTH'(0));
    exp_q.delete();
    last_q.delete();
    stat_b = 0;
    stat_p = 0;
    flush_fifo();
    step();
    rst = 1'b0;
`ifdef AXIS_FIFO_DRAIN_STATS_EN
    chk("t6_stat_beats", WIDTH'(stat_beats), WIDTH'(0));
    chk("t6_stat_pkts", WIDTH'(stat_pkts), WIDTH'(0));
`endif
    new_test(2, 1);
    tready = 1'b1;
    push_words(2, 2, 1'b1);
    enable = 1'b1;
    drain(100);
    settle_idle("t6_after");

`ifdef AXIS_FIFO_DRAIN_STATS_EN
    chk("stat_beats", WIDTH'(stat_beats), WIDTH'(stat_b));
    chk("stat_pkts", WIDTH'(stat_pkts), WIDTH'(stat_p));
`endif
    chk("fifo_underflow", WIDTH'(underflow_seen), WIDTH'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
